// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch unit slice.
package fetch_unit_pkg;

  localparam int unsigned INST_WIDTH = 32;
  localparam int unsigned PC_WIDTH   = 32;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_FULL = 2'd2
  } fetch_state_e;

  function automatic logic [PC_WIDTH-1:0] next_pc(input logic [PC_WIDTH-1:0] pc);
    return pc + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Decode-side handshake between the fetch unit (master) and its consumer (slave).
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int unsigned WIDTH = INST_WIDTH
);
  logic                out_valid;
  logic [WIDTH-1:0]    out_inst;
  logic [PC_WIDTH-1:0] out_pc;
  logic                out_ready;

  modport master (output out_valid, output out_inst, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_inst, input out_pc, output out_ready);
endinterface

// File: rtl/fetch_buf.sv
// Two-entry FIFO of {pc, instruction} words with synchronous flush.
module fetch_buf #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [DW-1:0]    din,
  output logic [DW-1:0]    dout,
  output logic [CNT_W-1:0] count
);

  logic [DW-1:0] mem [2];
  logic          head;
  logic          tail;

  assign dout = mem[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= '0;
    end else if (flush) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= '0;
    end else begin
      // When full, tail aliases head; the popped slot is refilled on the same edge.
      if (push) begin
        mem[tail] <= din;
        tail      <= ~tail;
      end
      if (pop) head <= ~head;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC generation into a 2-entry buffer, with redirect flush.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned WIDTH     = INST_WIDTH,
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       imem_pc,
  input  logic [WIDTH-1:0]  imem_inst,
  fetch_unit_if.master      out_bus
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_e      state;
  logic [31:0]       fetch_pc;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_after;
  logic [WIDTH+31:0] head;

  assign imem_pc           = fetch_pc;
  assign out_bus.out_valid = (count != '0);
  assign out_bus.out_pc    = head[WIDTH+31:WIDTH];
  assign out_bus.out_inst  = head[WIDTH-1:0];

  always_comb begin
    pop         = out_bus.out_valid && out_bus.out_ready && !redirect_valid;
    push        = !redirect_valid && en && (state == FETCH_RUN) &&
                  ((count < CNT_W'(BUF_DEPTH)) || pop);
    count_after = count + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH_IDLE;
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      state    <= en ? FETCH_RUN : FETCH_IDLE;
      fetch_pc <= redirect_pc;
    end else begin
      if (push) fetch_pc <= next_pc(fetch_pc);
      case (state)
        FETCH_IDLE: if (en) state <= FETCH_RUN;
        FETCH_RUN: begin
          if (!en)
            state <= FETCH_IDLE;
          else if (!pop && count_after == CNT_W'(BUF_DEPTH))
            state <= FETCH_FULL;
        end
        FETCH_FULL: if (pop) state <= FETCH_RUN;
        default:    state <= FETCH_IDLE;
      endcase
    end
  end

  fetch_buf #(
    .DW    (WIDTH + 32),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({imem_pc, imem_inst}),
    .dout  (head),
    .count (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model plus directed literal checkpoints.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'd0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;

  int checks = 0;
  int failures = 0;

  fetch_unit_if #(.WIDTH(32)) bus ();

  fetch_unit #(
    .WIDTH     (32),
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_pc        (imem_pc),
    .imem_inst      (imem_inst),
    .out_bus        (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h1234_5678;
  endfunction

  assign imem_inst = mem_f(imem_pc);

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: queue of fetched PCs, next PC to fetch, and two mode flags.
  logic [31:0] mq[$];
  logic [31:0] m_pc = RST_PC;
  bit          m_active = 0;
  bit          m_blocked = 0;
  bit          model_on = 0;

  always @(posedge clk or negedge rst_n) begin
    bit m_pop, m_push, running;
    if (!rst_n) begin
      mq.delete();
      m_pc      = RST_PC;
      m_active  = 0;
      m_blocked = 0;
    end else begin
      m_pop   = (mq.size() != 0) && bus.out_ready && !redirect_valid;
      m_push  = 0;
      running = m_active && !m_blocked;
      if (redirect_valid) begin
        mq.delete();
        m_pc      = redirect_pc;
        m_active  = en;
        m_blocked = 0;
      end else begin
        if (m_blocked) begin
          if (m_pop) m_blocked = 0;
        end else if (!m_active) m_active = en;
        else if (!en) m_active = 0;
        else m_push = (mq.size() < 2) || m_pop;
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          mq.push_back(m_pc);
          m_pc = m_pc + 32'd1;
        end
        if (running && en && !m_pop && mq.size() == 2) m_blocked = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && model_on) begin
      chk("model_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) begin
        chk("model_out_pc", bus.out_pc, mq[0]);
        chk("model_out_inst", bus.out_inst, mem_f(mq[0]));
      end
      chk("model_imem_pc", imem_pc, m_pc);
    end
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic r, input logic rv, input logic [31:0] rp);
    en             = e;
    bus.out_ready  = r;
    redirect_valid = rv;
    redirect_pc    = rp;
  endtask

  task automatic lit(input string nm, input logic v, input logic [31:0] pc, input logic [31:0] ipc);
    chk({nm, "_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    if (v) begin
      chk({nm, "_out_pc"}, bus.out_pc, pc);
      chk({nm, "_out_inst"}, bus.out_inst, mem_f(pc));
    end
    chk({nm, "_imem_pc"}, imem_pc, ipc);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    #3;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    chk("rst_out_inst", bus.out_inst, 32'd0);
    chk("rst_imem_pc", imem_pc, RST_PC);

    nxt();
    rst_n    = 1'b1;
    model_on = 1;
    drive(1, 0, 0, 0);
    nxt();           lit("idle_to_run", 0, 0, 0);
    nxt();           lit("first_push", 1, 0, 1);
    repeat (3) nxt();
    lit("stall_full", 1, 0, 2);
    drive(1, 1, 0, 0);
    nxt();           lit("release_pop0", 1, 1, 2);
    nxt();           lit("release_pop1", 1, 2, 3);
    nxt();           lit("stream3", 1, 3, 4);
    nxt();           lit("stream4", 1, 4, 5);
    drive(1, 0, 0, 0);
    nxt();           lit("hold45", 1, 4, 6);
    drive(1, 1, 1, 32'd3);
    nxt();           lit("redir_flush", 0, 0, 3);
    drive(1, 1, 0, 0);
    nxt();           lit("redir_first", 1, 3, 4);
    nxt();           lit("redir_second", 1, 4, 5);
    drive(0, 0, 0, 0);
    nxt();
    nxt();           lit("en_off_hold", 1, 4, 5);
    drive(0, 1, 0, 0);
    nxt();           lit("en_off_drain", 0, 0, 5);
    drive(1, 1, 1, 32'hFFFF_FFFF);
    nxt();           lit("wrap_redir", 0, 0, 32'hFFFF_FFFF);
    drive(1, 1, 0, 0);
    nxt();           lit("wrap_top", 1, 32'hFFFF_FFFF, 0);
    nxt();           lit("wrap_zero", 1, 0, 1);
    nxt();           lit("wrap_one", 1, 1, 2);

    for (int i = 0; i < 60; i++) begin
      drive((i % 7) != 5, (i % 3) != 0, (i % 11) == 4, 32'h100 + 32'(i * 5));
      nxt();
    end

    drive(1, 0, 0, 0);
    repeat (3) nxt();
    chk("pre_reset_valid", {31'd0, bus.out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_rst_out_pc", bus.out_pc, 32'd0);
    chk("async_rst_imem_pc", imem_pc, RST_PC);
    nxt();
    rst_n = 1'b1;
    drive(1, 1, 0, 0);
    nxt();           lit("post_rst_idle", 0, 0, RST_PC);
    nxt();           lit("post_rst_first", 1, RST_PC, RST_PC + 32'd1);
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
